csd_coef_writer: RTL
====================

# csd_coef_writer

Converts two's-complement Q1.15 filter coefficients into canonic-signed-digit (CSD) form, keeps at most NZZ nonzero digits, and writes the resulting shift/sign term list into the coefficient store of the multiplierless FIR datapath. It sits between the coefficient source (host register bank or ROM sequencer) and the filter's coefficient write port. It runs one coefficient at a time through a small FSM.

## Interface

- COEF_WIDTH, 16: coefficient width, Q1.15 two's complement.
- TAPS, 32: number of coefficient slots; sets the address width AW = $clog2(TAPS).
- NZZ, 4: maximum nonzero CSD digits kept per coefficient.
- SW, $clog2(COEF_WIDTH): width of the digit position field.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient offered.
- in_ready  out  1  high only in IDLE and never while rst is high.
- in_coef  in  COEF_WIDTH  signed coefficient.
- in_addr  in  AW  target tap index.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  AW  captured in_addr.
- wr_digits  out  NZZ*(2+SW)  slot k = {used, neg, pos}. Slot 0 holds the most significant kept digit.
- wr_approx  out  COEF_WIDTH+1  signed sum of the kept digits.
- wr_trunc  out  1  set if the full CSD form had more than NZZ nonzero digits.
- busy  out  1  high whenever the state is not IDLE.

## Operation

- States:
  - IDLE. A handshake (in_valid && in_ready) captures in_coef and in_addr, clears the digit register, and moves to ENCODE with cnt=0.
  - ENCODE, W=COEF_WIDTH cycles, processing bit i=cnt from the LSB:
    - x_{W} equals the sign bit; carry c starts at 0.
    - s = x_i + c.
    - s=1 and x_{i+1}=1 gives digit -1, c=1.
    - s=1 and x_{i+1}=0 gives digit +1, c=0.
    - s=2 gives digit 0, c=1.
    - s=0 gives digit 0, c=0.
    - After i=W-1 the FSM goes to SELECT.
  - SELECT, W cycles, scanning positions W-1 down to 0:
    - A nonzero digit with fewer than NZZ slots filled goes into the next slot as {1, neg, pos}, and ±2^pos is added to the approx accumulator.
    - A nonzero digit with all slots filled sets trunc.
  - WRITE, one cycle: wr_en=1. Digits, addr, approx and trunc are valid. Next state is IDLE.
- Unused slots are all zero.
- Dropped digits are discarded, not rounded: wr_approx = in_coef minus the dropped terms.
- Every in-range input, including -2^(W-1) and 2^(W-1)-1, fits in W digits. No digit exists at position W.
- A zero coefficient still produces a WRITE with all slots unused.
- in_valid outside IDLE is ignored. in_coef and in_addr need not stay stable after acceptance.

## Timing

- Handshake at cycle T gives wr_en at T+2W+1, which is T+33 for the default W.
- Next acceptance is no earlier than T+2W+2. Maximum throughput is one coefficient per 2W+2 cycles.
- wr_digits, wr_addr, wr_approx and wr_trunc are registered. They hold their values after WRITE until the next WRITE.
- Reset values: in_ready 0 while rst is high, 1 in the first cycle after release. wr_en, wr_addr, wr_digits, wr_approx, wr_trunc and busy are all 0.
- rst in any state forces IDLE and discards the in-flight coefficient. No wr_en is produced for it.

## Configuration

- CSD_WRITER_STATS_EN defined:
  - Adds outputs stat_coefs[15:0] (WRITE count) and stat_trunc[15:0] (WRITE count with trunc=1).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure

- Package csd_pkg:
  - csd_digit_t struct {used, neg, pos}.
  - Writer state enum {IDLE, ENCODE, SELECT, WRITE}.
  - Default COEF_WIDTH/NZZ constants.
- Sub-module csd_recode_step: combinational. Inputs x_i, x_{i+1}, c_in. Outputs nonzero, neg, c_out. Instantiated once in ENCODE.

## Test plan

- 415 at addr 0 → wr_en at T+33 with slots {+,9},{-,7},{+,5},{-,0}, approx 415, trunc 0.
- 0x5555 (21845) → slots {+,14},{+,12},{+,10},{+,8}, approx 21760, trunc 1.
- -32768 → slot0 {-,15}, approx -32768. -1 → slot0 {-,0}, approx -1. Other slots 0.
- 0 at addr 31 → wr_en with wr_addr 31, all slots unused, approx 0, trunc 0.
- in_valid held high with two coefficients → second accepted at T+34, second wr_en at T+67. in_ready low throughout busy.
- rst pulsed at T+10 → no wr_en for that coefficient. in_ready=1 on the cycle after rst falls. With CSD_WRITER_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/csd_pkg.sv
// csd_pkg: shared types and default sizes for the CSD coefficient writer.
//   csd_digit_t    : one kept CSD term {used, neg, pos} at default width
//   writer_state_t : IDLE -> ENCODE -> SELECT -> WRITE -> IDLE
//   CSD_COEF_WIDTH : default coefficient width (Q1.15)
//   CSD_NZZ        : default maximum number of kept nonzero digits
package csd_pkg;

    localparam int CSD_COEF_WIDTH = 16;
    localparam int CSD_NZZ        = 4;

    typedef struct packed {
        logic                              used;
        logic                              neg;
        logic [$clog2(CSD_COEF_WIDTH)-1:0] pos;
    } csd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        SELECT = 2'd2,
        WRITE  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/csd_recode_step.sv
// csd_recode_step: one bit of the two's-complement to CSD recoding.
//   x_i     in  current coefficient bit
//   x_ip1   in  next higher bit (sign bit when x_i is the MSB)
//   c_in    in  carry from the lower position
//   nonzero out digit at this position is +/-1
//   neg     out digit is -1 (only meaningful when nonzero)
//   c_out   out carry into the next position
module csd_recode_step (
    input  logic x_i,
    input  logic x_ip1,
    input  logic c_in,
    output logic nonzero,
    output logic neg,
    output logic c_out
);

    // s = x_i + c_in. An odd sum yields a digit; it becomes -1 (with a carry)
    // when the next bit is also set, which is what keeps nonzero digits apart.
    always_comb begin
        nonzero = x_i ^ c_in;
        neg     = nonzero & x_ip1;
        c_out   = (x_i & c_in) | (nonzero & x_ip1);
    end

endmodule

// File: rtl/csd_coef_writer.sv
// csd_coef_writer: recodes one Q1.15 coefficient at a time into CSD, keeps the
// NZZ most significant nonzero digits and writes the term list to the FIR
// coefficient store.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     coefficient handshake (ready only in IDLE)
//   in_coef, in_addr      signed coefficient and target tap index
//   wr_en                 one-cycle write strobe
//   wr_addr               tap index of the written coefficient
//   wr_digits             NZZ slots {used, neg, pos}, slot 0 = most significant
//   wr_approx             signed sum of the kept digits
//   wr_trunc              more than NZZ nonzero digits existed
//   busy                  state is not IDLE
// Optional build macro CSD_WRITER_STATS_EN adds saturating counters
//   stat_coefs (writes) and stat_trunc (writes with wr_trunc set).
module csd_coef_writer
    import csd_pkg::*;
#(
    parameter  int COEF_WIDTH = CSD_COEF_WIDTH,
    parameter  int TAPS       = 32,
    parameter  int NZZ        = CSD_NZZ,
    parameter  int SW         = $clog2(COEF_WIDTH),
    localparam int AW         = $clog2(TAPS),
    localparam int DW         = 2 + SW,
    localparam int FW         = $clog2(NZZ + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COEF_WIDTH-1:0]   in_coef,
    input  logic [AW-1:0]           in_addr,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [NZZ*DW-1:0]       wr_digits,
    output logic signed [COEF_WIDTH:0] wr_approx,
    output logic                    wr_trunc,
    output logic                    busy
`ifdef CSD_WRITER_STATS_EN
    ,
    output logic [15:0]             stat_coefs,
    output logic [15:0]             stat_trunc
`endif
);

    writer_state_t          state, state_nxt;
    logic [SW-1:0]          cnt, cnt_nxt;
    logic                   accept;

    // Working copy of the accepted coefficient and its recoding.
    logic [COEF_WIDTH-1:0]  coef_q;
    logic [AW-1:0]          addr_q;
    logic                   carry_q;
    logic [COEF_WIDTH-1:0]  dig_nz_q;
    logic [COEF_WIDTH-1:0]  dig_neg_q;
    logic [NZZ*DW-1:0]      slots_q, slots_nxt;
    logic [FW-1:0]          nfill_q, nfill_nxt;
    logic [COEF_WIDTH:0]    approx_q, approx_nxt;
    logic                   trunc_q, trunc_nxt;

    // Recoder inputs: the bit above the MSB is the sign bit.
    logic [COEF_WIDTH:0]    x_ext;
    logic [SW:0]            cnt_p1;
    logic                   rc_nonzero, rc_neg, rc_c_out;

    logic                   sel_nz, sel_neg;
    logic [COEF_WIDTH:0]    term;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign wr_en    = (state == WRITE);

    assign x_ext  = {coef_q[COEF_WIDTH-1], coef_q};
    assign cnt_p1 = {1'b0, cnt} + (SW+1)'(1);

    csd_recode_step u_step (
        .x_i     (coef_q[cnt]),
        .x_ip1   (x_ext[cnt_p1]),
        .c_in    (carry_q),
        .nonzero (rc_nonzero),
        .neg     (rc_neg),
        .c_out   (rc_c_out)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ENCODE;
                    cnt_nxt   = '0;
                end
            end
            ENCODE: begin
                if (cnt == SW'(COEF_WIDTH - 1)) begin
                    state_nxt = SELECT;   // SELECT scans from the MSB down
                end else begin
                    cnt_nxt = cnt + SW'(1);
                end
            end
            SELECT: begin
                if (cnt == '0) begin
                    state_nxt = WRITE;
                end else begin
                    cnt_nxt = cnt - SW'(1);
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit selection for the position currently addressed by cnt. Slots fill
    // in scan order, so slot 0 always receives the most significant digit.
    always_comb begin
        sel_nz     = dig_nz_q[cnt];
        sel_neg    = dig_neg_q[cnt];
        term       = '0;
        term[cnt]  = 1'b1;
        slots_nxt  = slots_q;
        nfill_nxt  = nfill_q;
        approx_nxt = approx_q;
        trunc_nxt  = trunc_q;
        if (sel_nz) begin
            if (nfill_q < FW'(NZZ)) begin
                for (int k = 0; k < NZZ; k++) begin
                    if (nfill_q == FW'(k)) begin
                        slots_nxt[k*DW +: DW] = {1'b1, sel_neg, cnt};
                    end
                end
                nfill_nxt  = nfill_q + FW'(1);
                approx_nxt = sel_neg ? (approx_q - term) : (approx_q + term);
            end else begin
                trunc_nxt = 1'b1;   // dropped, not rounded
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_addr   <= '0;
            wr_digits <= '0;
            wr_approx <= '0;
            wr_trunc  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Load the result on the last SELECT step so it is stable during
            // WRITE and held until the next WRITE.
            if (state == SELECT && cnt == '0) begin
                wr_addr   <= addr_q;
                wr_digits <= slots_nxt;
                wr_approx <= approx_nxt;
                wr_trunc  <= trunc_nxt;
            end
        end
    end

    // NOTE: the working registers carry no reset: each acceptance reloads or
    // clears all of them before they are read, and rst already forces IDLE.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: begin
                if (accept) begin
                    coef_q    <= in_coef;
                    addr_q    <= in_addr;
                    carry_q   <= 1'b0;
                    dig_nz_q  <= '0;
                    dig_neg_q <= '0;
                    slots_q   <= '0;
                    nfill_q   <= '0;
                    approx_q  <= '0;
                    trunc_q   <= 1'b0;
                end
            end
            ENCODE: begin
                dig_nz_q[cnt]  <= rc_nonzero;
                dig_neg_q[cnt] <= rc_neg;
                carry_q        <= rc_c_out;
            end
            SELECT: begin
                slots_q  <= slots_nxt;
                nfill_q  <= nfill_nxt;
                approx_q <= approx_nxt;
                trunc_q  <= trunc_nxt;
            end
            default: ;
        endcase
    end

`ifdef CSD_WRITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_coefs <= '0;
            stat_trunc <= '0;
        end else if (state == WRITE) begin
            if (stat_coefs != 16'hFFFF) begin
                stat_coefs <= stat_coefs + 16'd1;
            end
            if (wr_trunc && stat_trunc != 16'hFFFF) begin
                stat_trunc <= stat_trunc + 16'd1;
            end
        end
    end
`endif

endmodule
